// File: rtl/wb_arbiter_if.sv
// Write-back arbiter bus: ALU results, load issue/response handshakes,
// decode-stage hazard query and the register-file write port.
interface wb_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             alu_valid;
    logic [4:0]       alu_rd;
    logic [WIDTH-1:0] alu_data;
    logic             ld_issue;
    logic [4:0]       ld_issue_rd;
    logic             ld_issue_ready;
    logic             ld_resp_valid;
    logic [WIDTH-1:0] ld_resp_data;
    logic             ld_resp_ready;
    logic [4:0]       chk_rs1;
    logic [4:0]       chk_rs2;
    logic [4:0]       chk_rd;
    logic             hazard;
    logic [4:0]       writereg;
    logic [WIDTH-1:0] data;
    logic             writeEn;
    logic             err;

    // Pipeline side: drives results, loads and decode indices.
    modport master (
        output alu_valid, alu_rd, alu_data,
        output ld_issue, ld_issue_rd, ld_resp_valid, ld_resp_data,
        output chk_rs1, chk_rs2, chk_rd,
        input  ld_issue_ready, ld_resp_ready, hazard,
        input  writereg, data, writeEn, err
    );

    // Arbiter side.
    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  ld_issue, ld_issue_rd, ld_resp_valid, ld_resp_data,
        input  chk_rs1, chk_rs2, chk_rd,
        output ld_issue_ready, ld_resp_ready, hazard,
        output writereg, data, writeEn, err
    );
endinterface

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges ALU results and in-order load responses onto
// the single register-file write port, buffers displaced load data and
// tracks outstanding load destinations for decode hazard detection.
module wb_arbiter #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input logic         clk,
    input logic         rst,
    wb_arbiter_if.slave wb
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // Tag queue (load destinations) and data buffer (early load responses).
    logic [4:0]       tag_mem_q [DEPTH];
    logic [WIDTH-1:0] buf_mem_q [DEPTH];
    logic [AW-1:0]    tag_rp_q, tag_rp_d, tag_wp_q, tag_wp_d;
    logic [AW-1:0]    buf_rp_q, buf_rp_d, buf_wp_q, buf_wp_d;
    logic [CW-1:0]    tag_cnt_q, tag_cnt_d, buf_cnt_q, buf_cnt_d;
    logic [31:0]      pend_q, pend_d;
    logic             err_q, err_d;
    logic [4:0]       wreg_q, wreg_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic             wen_q, wen_d;

    logic             iss_acc, rsp_hs, rsp_acc;
    logic             tag_push, tag_pop, buf_push, buf_pop;
    logic             commit;
    logic [4:0]       commit_rd;
    logic [WIDTH-1:0] commit_data;

    // Commit selection (ALU > buffered load > bypassed response) and next state.
    always_comb begin
        iss_acc     = wb.ld_issue && (tag_cnt_q < FULL);
        rsp_hs      = wb.ld_resp_valid && (buf_cnt_q < FULL);
        // A response is only meaningful if some tag is still waiting for data.
        rsp_acc     = rsp_hs && (tag_cnt_q != buf_cnt_q);
        commit      = 1'b0;
        commit_rd   = '0;
        commit_data = '0;
        tag_pop     = 1'b0;
        buf_pop     = 1'b0;
        buf_push    = 1'b0;
        tag_push    = iss_acc;

        if (wb.alu_valid) begin
            commit      = 1'b1;
            commit_rd   = wb.alu_rd;
            commit_data = wb.alu_data;
            buf_push    = rsp_acc;
        end else if (buf_cnt_q != '0) begin
            commit      = 1'b1;
            commit_rd   = tag_mem_q[tag_rp_q];
            commit_data = buf_mem_q[buf_rp_q];
            tag_pop     = 1'b1;
            buf_pop     = 1'b1;
            buf_push    = rsp_acc;
        end else if (rsp_acc) begin
            commit      = 1'b1;
            commit_rd   = tag_mem_q[tag_rp_q];
            commit_data = wb.ld_resp_data;
            tag_pop     = 1'b1;
        end

        tag_cnt_d = tag_cnt_q + CW'(tag_push) - CW'(tag_pop);
        buf_cnt_d = buf_cnt_q + CW'(buf_push) - CW'(buf_pop);
        tag_wp_d  = tag_wp_q + AW'(tag_push);
        tag_rp_d  = tag_rp_q + AW'(tag_pop);
        buf_wp_d  = buf_wp_q + AW'(buf_push);
        buf_rp_d  = buf_rp_q + AW'(buf_pop);

        // Clear on load commit first so a same-cycle re-issue to that rd wins.
        pend_d = pend_q;
        if (tag_pop) begin
            pend_d[commit_rd] = 1'b0;
        end
        if (iss_acc && (wb.ld_issue_rd != 5'd0)) begin
            pend_d[wb.ld_issue_rd] = 1'b1;
        end

        err_d   = err_q | (rsp_hs && (tag_cnt_q == buf_cnt_q));
        wen_d   = commit && (commit_rd != 5'd0);
        wreg_d  = commit ? commit_rd : wreg_q;
        wdata_d = commit ? commit_data : wdata_q;
    end

    // Control state and registered write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_rp_q  <= '0;
            tag_wp_q  <= '0;
            buf_rp_q  <= '0;
            buf_wp_q  <= '0;
            tag_cnt_q <= '0;
            buf_cnt_q <= '0;
            pend_q    <= '0;
            err_q     <= 1'b0;
            wen_q     <= 1'b0;
            wreg_q    <= '0;
            wdata_q   <= '0;
        end else begin
            tag_rp_q  <= tag_rp_d;
            tag_wp_q  <= tag_wp_d;
            buf_rp_q  <= buf_rp_d;
            buf_wp_q  <= buf_wp_d;
            tag_cnt_q <= tag_cnt_d;
            buf_cnt_q <= buf_cnt_d;
            pend_q    <= pend_d;
            err_q     <= err_d;
            wen_q     <= wen_d;
            wreg_q    <= wreg_d;
            wdata_q   <= wdata_d;
        end
    end

    // FIFO storage; contents are qualified by the counters, so no reset.
    always_ff @(posedge clk) begin
        if (tag_push) begin
            tag_mem_q[tag_wp_q] <= wb.ld_issue_rd;
        end
        if (buf_push) begin
            buf_mem_q[buf_wp_q] <= wb.ld_resp_data;
        end
    end

    assign wb.ld_issue_ready = (tag_cnt_q < FULL);
    assign wb.ld_resp_ready  = (buf_cnt_q < FULL);
    assign wb.hazard   = ((wb.chk_rs1 != 5'd0) && pend_q[wb.chk_rs1]) ||
                         ((wb.chk_rs2 != 5'd0) && pend_q[wb.chk_rs2]) ||
                         ((wb.chk_rd  != 5'd0) && pend_q[wb.chk_rd]);
    assign wb.writereg = wreg_q;
    assign wb.data     = wdata_q;
    assign wb.writeEn  = wen_q;
    assign wb.err      = err_q;
endmodule
